// File: rtl/crypt_pkg.sv
// Shared definitions for the mask-and-add crypt blocks.
//   ENC / DEC   : encodings of the one-bit mode field
//   DEF_*       : default widths, LFSR seed and Galois feedback taps
//   out_w()     : packed word width {key, x[DATA_W:0], tag}
package crypt_pkg;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  localparam int DEF_DATA_W = 60;
  localparam int DEF_KEY_W  = 11;
  localparam int DEF_TAG_W  = 6;

  localparam logic [10:0] DEF_SEED = 11'h001;
  localparam logic [10:0] DEF_TAPS = 11'h005;

  // Key field, masked sum with its carry bit, then tag.
  function automatic int out_w(input int data_w, input int key_w, input int tag_w);
    return key_w + data_w + 1 + tag_w;
  endfunction

endpackage

// File: rtl/mask_add_crypt_pipe_if.sv
// Handshake bundle between the data source, the crypt pipe and the channel packer.
//   in_valid/in_ready/in_mode/in_word    : request channel (source -> pipe)
//   out_valid/out_ready/out_mode/
//   out_word/out_err                     : result channel (pipe -> packer)
// master = the testbench/system side driving requests and accepting results,
// slave  = the crypt pipe itself.
interface mask_add_crypt_pipe_if import crypt_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEY_W  = DEF_KEY_W,
  parameter int TAG_W  = DEF_TAG_W
);

  localparam int OUT_W = out_w(DATA_W, KEY_W, TAG_W);

  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [OUT_W-1:0] in_word;

  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [OUT_W-1:0] out_word;
  logic             out_err;

  modport master (
    output in_valid, in_mode, in_word, out_ready,
    input  in_ready, out_valid, out_mode, out_word, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_word, out_ready,
    output in_ready, out_valid, out_mode, out_word, out_err
  );

endinterface

// File: rtl/crypt_mask_gen.sv
// Combinational key -> mask expansion.
//   key  in  KEY_W  : mask seed
//   mask out DATA_W : KEY_W-bit groups, LSB group first; groups whose index
//                     mod 4 is 2 or 3 carry ~key, the others carry key. The
//                     top partial group keeps only the low bits of its value.
module crypt_mask_gen import crypt_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEY_W  = DEF_KEY_W
) (
  input  logic [KEY_W-1:0]  key,
  output logic [DATA_W-1:0] mask
);

  // Each mask bit maps to a fixed key bit, so the whole expansion is wiring
  // plus inverters; the partial top group falls out of the truncated loop.
  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    localparam int GRP = i / KEY_W;
    localparam int BIT = i % KEY_W;
    if ((GRP % 4) >= 2) begin : g_inv
      assign mask[i] = ~key[BIT];
    end else begin : g_pass
      assign mask[i] = key[BIT];
    end
  end

endmodule

// File: rtl/mask_add_crypt_pipe.sv
// Two-stage pipelined mask-and-add encryptor/decryptor.
//   clk       in  : rising-edge clock
//   rst_n     in  : asynchronous active-low reset
//   seed_load in  : reload the key LFSR from seed_val (0 loads 1)
//   seed_val  in  : new LFSR seed
//   bus       slave modport of mask_add_crypt_pipe_if:
//     encrypt: out_word = {key, data + mask (with carry), tag}, key from the
//              LFSR, tag from a wrapping counter; both advance on acceptance.
//     decrypt: out_word = {0, 0, x - mask, tag} with key/x/tag unpacked from
//              in_word; out_err flags a borrow out of x - mask.
module mask_add_crypt_pipe import crypt_pkg::*; #(
  parameter int               DATA_W = DEF_DATA_W,
  parameter int               KEY_W  = DEF_KEY_W,
  parameter int               TAG_W  = DEF_TAG_W,
  parameter logic [KEY_W-1:0] SEED   = KEY_W'(DEF_SEED),
  parameter logic [KEY_W-1:0] TAPS   = KEY_W'(DEF_TAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_load,
  input  logic [KEY_W-1:0]      seed_val,
  mask_add_crypt_pipe_if.slave  bus
);

  localparam int OUT_W = out_w(DATA_W, KEY_W, TAG_W);
  localparam int X_W   = DATA_W + 1;

  // Key/tag generator state
  logic [KEY_W-1:0]  lfsr;
  logic [KEY_W-1:0]  lfsr_next;
  logic [TAG_W-1:0]  tag_cnt;

  // Request decode
  logic              adv_p1;
  logic              adv_p2;
  logic              in_fire;
  logic              enc_fire;
  logic [KEY_W-1:0]  key_sel;
  logic [X_W-1:0]    x_sel;
  logic [TAG_W-1:0]  tag_sel;
  logic [DATA_W-1:0] mask_sel;

  // Stage 1 registers
  logic              vld_p1;
  logic              mode_p1;
  logic [KEY_W-1:0]  key_p1;
  logic [DATA_W-1:0] mask_p1;
  logic [X_W-1:0]    x_p1;
  logic [TAG_W-1:0]  tag_p1;

  // Stage 2 inputs and registers
  logic [OUT_W-1:0]  word_d;
  logic              err_d;
  logic              vld_p2;
  logic              mode_p2;
  logic [OUT_W-1:0]  word_p2;
  logic              err_p2;

  // Galois step: shift left, fold the tap mask in when the MSB falls out.
  function automatic logic [KEY_W-1:0] lfsr_step(input logic [KEY_W-1:0] cur);
    return {cur[KEY_W-2:0], 1'b0} ^ (cur[KEY_W-1] ? TAPS : '0);
  endfunction

  // A zero seed would lock the LFSR at zero forever.
  function automatic logic [KEY_W-1:0] seed_fix(input logic [KEY_W-1:0] val);
    return (val == '0) ? KEY_W'(1) : val;
  endfunction

  // Handshake: each stage moves when the stage ahead of it can take its word,
  // so a full pipe accepts and drains in the same cycle without a bubble.
  assign adv_p2       = !vld_p2 || bus.out_ready;
  assign adv_p1       = !vld_p1 || adv_p2;
  assign bus.in_ready = rst_n && adv_p1;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign enc_fire     = in_fire && (bus.in_mode == ENC);

  assign lfsr_next = lfsr_step(lfsr);

  // Encrypt takes key/tag from the generators; decrypt unpacks them.
  always_comb begin
    key_sel = lfsr;
    x_sel   = {1'b0, bus.in_word[DATA_W-1:0]};
    tag_sel = tag_cnt;
    if (bus.in_mode == DEC) begin
      key_sel = bus.in_word[OUT_W-1 -: KEY_W];
      x_sel   = bus.in_word[TAG_W +: X_W];
      tag_sel = bus.in_word[TAG_W-1:0];
    end
  end

  crypt_mask_gen #(
    .DATA_W (DATA_W),
    .KEY_W  (KEY_W)
  ) u_mask_gen (
    .key  (key_sel),
    .mask (mask_sel)
  );

  // The seed overrides the advance; the transaction accepted this cycle has
  // already sampled the old key through key_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= SEED;
      tag_cnt <= '0;
    end else begin
      if (seed_load) begin
        lfsr <= seed_fix(seed_val);
      end else if (enc_fire) begin
        lfsr <= lfsr_next;
      end
      if (enc_fire) begin
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
    end
  end

  // ---- stage 0 -> stage 1: capture mode, key, mask, operand, tag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      mode_p1 <= ENC;
      key_p1  <= '0;
      mask_p1 <= '0;
      x_p1    <= '0;
      tag_p1  <= '0;
    end else if (adv_p1) begin
      vld_p1 <= in_fire;
      if (in_fire) begin
        mode_p1 <= bus.in_mode;
        key_p1  <= key_sel;
        mask_p1 <= mask_sel;
        x_p1    <= x_sel;
        tag_p1  <= tag_sel;
      end
    end
  end

  // Both directions work at DATA_W+1 bits: the top bit is the kept carry on
  // encrypt and the borrow (error flag) on decrypt.
  always_comb begin
    logic [X_W-1:0] sum;
    logic [X_W-1:0] diff;
    sum    = x_p1 + {1'b0, mask_p1};
    diff   = x_p1 - {1'b0, mask_p1};
    word_d = {key_p1, sum, tag_p1};
    err_d  = 1'b0;
    if (mode_p1 == DEC) begin
      word_d = {{KEY_W{1'b0}}, 1'b0, diff[DATA_W-1:0], tag_p1};
      err_d  = diff[DATA_W];
    end
  end

  // ---- stage 1 -> stage 2: register the add/sub result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      mode_p2 <= ENC;
      word_p2 <= '0;
      err_p2  <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        mode_p2 <= mode_p1;
        word_p2 <= word_d;
        err_p2  <= err_d;
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_mode  = mode_p2;
  assign bus.out_word  = word_p2;
  assign bus.out_err   = err_p2;

endmodule

// File: doc/mask_add_crypt_pipe.md
# mask_add_crypt_pipe

Parametrised, pipelined successor to the single-cycle mask-and-add encryptor. Each transaction either encrypts (plaintext + key-derived mask, key and tag appended) or decrypts (strips key/tag, subtracts mask, flags invalid words). Keys come from an internal reseedable LFSR and tags from a wrapping counter. The block sits between the data source and the channel packer, with valid/ready handshakes on both sides.

## Interface
- DATA_W, 60: plaintext width
- KEY_W, 11: key width and mask group width
- TAG_W, 6: tag width
- SEED, 11'h001: LFSR reset value (must be nonzero)
- TAPS, 11'h005: LFSR Galois feedback mask
- Derived: OUT_W = KEY_W + DATA_W + 1 + TAG_W (78 by default)

Ports:
- Clk in 1: clock, rising edge
- Rst_n in 1: asynchronous active-low reset
- in_valid in 1: input word valid
- in_ready out 1: block can accept
- in_mode in 1: 0 = encrypt, 1 = decrypt
- in_word in OUT_W: encrypt uses bits [DATA_W-1:0]; decrypt uses the full packed word
- out_valid out 1: result valid
- out_ready in 1: sink accepts
- out_mode out 1: mode of the result
- out_word out OUT_W: encrypt gives {key, x[DATA_W:0], tag}; decrypt gives {KEY_W'0, 1'b0, plaintext, tag}
- out_err out 1: decrypt underflow/overflow; always 0 for encrypt
- seed_load in 1: reseed the LFSR
- seed_val in KEY_W: new seed

## Operation
- Mask generation
  - Split the DATA_W-bit mask into KEY_W-bit groups g = 0, 1, …, LSB first.
  - Group g = ~key if (g mod 4) is 2 or 3; otherwise group g = key.
  - The top partial group takes the low bits of the value it would otherwise hold.
- Encrypt
  - key = current LFSR value; tag = current tag counter.
  - x = data + mask, computed at DATA_W+1 bits with the carry kept.
  - Output {key, x, tag}.
  - On acceptance, advance both the LFSR and the tag counter.
- Decrypt
  - key = in_word[OUT_W-1 -: KEY_W]; x = middle DATA_W+1 bits; tag = low TAG_W bits.
  - r = x − mask at DATA_W+1 bits.
  - plaintext = r[DATA_W-1:0]; out_err = r[DATA_W].
  - The LFSR and tag counter are not touched.
- LFSR
  - next = {lfsr[KEY_W-2:0], 0} ^ (lfsr[KEY_W-1] ? TAPS : 0).
- Tag counter
  - TAG_W bits; wraps from all-ones to 0.
- Seeding
  - seed_load loads seed_val; a zero seed_val loads 1.
  - If seed_load coincides with an accepted encrypt, that transaction uses the old key, and the seed wins over the advance.

## Timing
- Reset values: lfsr = SEED, tag = 0, both pipeline valids = 0, out_valid = 0, out_word = 0, out_err = 0, out_mode = 0. in_ready = 1 while Rst_n is high and the pipe is empty.
- Two register stages:
  - S1 registers mode, key, mask, operands and tag.
  - S2 registers the add/sub result.
- Latency: 2 cycles from in_valid&&in_ready to out_valid. Throughput is 1 transaction per cycle.
- Handshake rules:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = !s1_valid || S2 advances.
  - out_word, out_mode and out_err hold stable while out_valid && !out_ready.
  - No bubble is inserted on simultaneous accept and drain.
- Full: with out_ready held low, at most 2 transactions are buffered, then in_ready drops. No drops and no reordering.
- Reset asserted mid-operation: all in-flight transactions are discarded and all state returns to the reset values immediately (asynchronous).

## Structure
- Shared package `crypt_pkg`:
  - mode encoding constants (ENC = 0, DEC = 1)
  - default widths, SEED and TAPS
  - an OUT_W helper function
- One sub-module, `crypt_mask_gen` (combinational key → mask, parametrised by DATA_W and KEY_W). The future mask-based decryptors reuse it.
- The LFSR, tag counter and pipeline control live in the top module.

## Test plan
- Encrypt after reset, data 0, no reseed:
  - out_word = {11'h001, 61'(mask), 6'h00}, where mask = {5'h01, 11'h001, 11'h7FE, 11'h7FE, 11'h001, 11'h001}.
  - Two cycles later: the second encrypt's key is 11'h002 and its tag is 6'h01.
- Seed 11'h7FF, encrypt data = all ones:
  - The carry sets x[60] = 1.
  - Decrypting that output word returns the all-ones plaintext with out_err = 0.
- Decrypt a word with key 11'h001 and x = 0:
  - out_err = 1, and the LFSR and tag are unchanged (next encrypt still uses the expected key).
- out_ready low for 5 cycles while 4 encrypts are offered back-to-back:
  - in_ready drops after 2 accepts.
  - After release, all 4 outputs appear in order with tags 0..3.
- seed_load with seed_val = 0 together with an accepted encrypt:
  - That encrypt uses the old key; the next key is 11'h001.
- Tag wrap and reset:
  - 64 encrypts wrap the tag to 0.
  - Rst_n pulsed low with 2 words in flight gives out_valid = 0 at once, and nothing emerges after release.
